alu_decode_stage: RTL and testbench

//  Decode/issue stage directly upstream of the integer ALU (base) in the RV64IMFD core.

---
 rtl/alu_pkg.sv | 82 ++++++++
 rtl/rv_imm_gen.sv | 26 ++
 rtl/alu_decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU decode definitions: select codes, opcode/funct constants, decode control payload.
package alu_pkg;

  localparam int unsigned ALU_SEL_W = 5;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned IMM_FMT_W = 3;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC, ALU_SLLI, ALU_SRLI, ALU_SRAI,
    ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
    ALU_ADDIW, ALU_SLLIW, ALU_SRLIW, ALU_SRAIW,
    ALU_FENCE, ALU_FENCE_TSO, ALU_PAUSE, ALU_ECALL, ALU_EBREAK
  } alu_op_e;

  typedef enum logic [IMM_FMT_W-1:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_src_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM, OP2_SHAMT} op2_src_e;

  typedef struct packed {
    alu_op_e  sel;
    op1_src_e op1_src;
    op2_src_e op2_src;
    logic     wb;
    logic     ill;
  } dec_ctrl_t;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] FENCE_FM_NORM = 4'b0000;
  localparam logic [3:0] FENCE_FM_TSO  = 4'b1000;
  localparam logic [3:0] FENCE_RW      = 4'b0011;
  localparam logic [3:0] FENCE_W       = 4'b0001;
  localparam logic [3:0] FENCE_NONE    = 4'b0000;

  // Register-register / register-immediate base ops share the funct3 mapping.
  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt);
    alu_op_e res;
    case (f3)
      F3_ADD_SUB: res = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     res = ALU_SLL;
      F3_SLT:     res = ALU_SLT;
      F3_SLTU:    res = ALU_SLTU;
      F3_XOR:     res = ALU_XOR;
      F3_SRL_SRA: res = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      res = ALU_OR;
      default:    res = ALU_AND;
    endcase
    return res;
  endfunction

  function automatic dec_ctrl_t mk_dec(input alu_op_e sel, input op1_src_e s1,
                                       input op2_src_e s2, input logic wb);
    dec_ctrl_t d;
    d.sel     = sel;
    d.op1_src = s1;
    d.op2_src = s2;
    d.wb      = wb;
    d.ill     = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// RISC-V immediate extraction for I/S/B/U/J formats, sign-extended to XLEN.
module rv_imm_gen
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]          instr_i,
  input  logic [IMM_FMT_W-1:0] fmt_i,
  output logic [XLEN-1:0]      imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I: imm_o = XLEN'($signed(instr_i[31:20]));
      IMM_S: imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      IMM_B: imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                    instr_i[11:8], 1'b0}));
      IMM_U: imm_o = XLEN'($signed({instr_i[31:12], 12'h000}));
      IMM_J: imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                    instr_i[30:21], 1'b0}));
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode/issue stage ahead of the integer ALU: decodes one instruction into a
// registered operand pair, select code and writeback control behind a valid/ready slot.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SEL_W = ALU_SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    op1,
  output logic [XLEN-1:0]    op2,
  output logic [SEL_W-1:0]   select,
  output logic [REG_AW-1:0]  rd,
  output logic               rd_we,
  output logic               illegal
);

  localparam bit          IS_RV64 = (XLEN == 64);
  localparam int unsigned SHAMT_W = IS_RV64 ? 6 : 5;

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [REG_AW-1:0] rd_a;
  logic [REG_AW-1:0] rs1_a;
  logic [3:0]        fence_fm, fence_pred, fence_succ;
  logic              shift_ok, w_shift_ok;
  imm_fmt_e          imm_fmt;
  logic [XLEN-1:0]   imm;
  dec_ctrl_t         dec;

  logic [XLEN-1:0]   op1_d, op2_d, op1_q, op2_q;
  alu_op_e           sel_q;
  logic [REG_AW-1:0] rd_q;
  logic              rd_we_d, rd_we_q, ill_q;
  logic              valid_d, valid_q, load;

  assign opcode     = in_instr[6:0];
  assign f3         = in_instr[14:12];
  assign f7         = in_instr[31:25];
  assign rd_a       = in_instr[11:7];
  assign rs1_a      = in_instr[19:15];
  assign fence_fm   = in_instr[31:28];
  assign fence_pred = in_instr[27:24];
  assign fence_succ = in_instr[23:20];

  // RV32 has no shamt[5]; SRAI/SRAIW alone may set instr[30].
  assign shift_ok   = (in_instr[31:26] == 6'b000000 ||
                       (in_instr[31:26] == 6'b010000 && f3 == F3_SRL_SRA)) &&
                      (IS_RV64 || !in_instr[25]);
  assign w_shift_ok = (f7 == F7_BASE) || (f7 == F7_ALT && f3 == F3_SRL_SRA);

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (in_instr[31:7]),
    .fmt_i   (imm_fmt),
    .imm_o   (imm)
  );

  // Instruction decode; anything not explicitly matched stays illegal.
  always_comb begin
    dec     = '{sel: ALU_ADD, op1_src: OP1_ZERO, op2_src: OP2_ZERO, wb: 1'b0, ill: 1'b1};
    imm_fmt = IMM_I;
    case (opcode)
      OPC_LUI: begin
        imm_fmt = IMM_U;
        dec     = mk_dec(ALU_LUI, OP1_ZERO, OP2_IMM, 1'b1);
      end
      OPC_AUIPC: begin
        imm_fmt = IMM_U;
        dec     = mk_dec(ALU_AUIPC, OP1_PC, OP2_IMM, 1'b1);
      end
      OPC_OP: begin
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)))
          dec = mk_dec(base_op(f3, f7[5]), OP1_RS1, OP2_RS2, 1'b1);
      end
      OPC_OP_IMM: begin
        if (f3 == F3_SLL) begin
          if (shift_ok) dec = mk_dec(ALU_SLLI, OP1_RS1, OP2_SHAMT, 1'b1);
        end else if (f3 == F3_SRL_SRA) begin
          if (shift_ok)
            dec = mk_dec(in_instr[30] ? ALU_SRAI : ALU_SRLI, OP1_RS1, OP2_SHAMT, 1'b1);
        end else begin
          dec = mk_dec(base_op(f3, 1'b0), OP1_RS1, OP2_IMM, 1'b1);
        end
      end
      OPC_OP_IMM_32: begin
        if (IS_RV64) begin
          if (f3 == F3_ADD_SUB)
            dec = mk_dec(ALU_ADDIW, OP1_RS1, OP2_IMM, 1'b1);
          else if (f3 == F3_SLL && f7 == F7_BASE)
            dec = mk_dec(ALU_SLLIW, OP1_RS1, OP2_SHAMT, 1'b1);
          else if (f3 == F3_SRL_SRA && w_shift_ok)
            dec = mk_dec(f7[5] ? ALU_SRAIW : ALU_SRLIW, OP1_RS1, OP2_SHAMT, 1'b1);
        end
      end
      OPC_OP_32: begin
        if (IS_RV64) begin
          if (f3 == F3_ADD_SUB && (f7 == F7_BASE || f7 == F7_ALT))
            dec = mk_dec(f7[5] ? ALU_SUBW : ALU_ADDW, OP1_RS1, OP2_RS2, 1'b1);
          else if (f3 == F3_SLL && f7 == F7_BASE)
            dec = mk_dec(ALU_SLLW, OP1_RS1, OP2_RS2, 1'b1);
          else if (f3 == F3_SRL_SRA && w_shift_ok)
            dec = mk_dec(f7[5] ? ALU_SRAW : ALU_SRLW, OP1_RS1, OP2_RS2, 1'b1);
        end
      end
      OPC_MISC_MEM: begin
        if (f3 == F3_ADD_SUB) begin
          if (fence_fm == FENCE_FM_TSO && fence_pred == FENCE_RW && fence_succ == FENCE_RW)
            dec = mk_dec(ALU_FENCE_TSO, OP1_ZERO, OP2_ZERO, 1'b0);
          else if (fence_fm == FENCE_FM_NORM && fence_pred == FENCE_W &&
                   fence_succ == FENCE_NONE)
            dec = mk_dec(ALU_PAUSE, OP1_ZERO, OP2_ZERO, 1'b0);
          else
            dec = mk_dec(ALU_FENCE, OP1_ZERO, OP2_ZERO, 1'b0);
        end
      end
      OPC_SYSTEM: begin
        if (f3 == F3_ADD_SUB && rs1_a == '0 && rd_a == '0 && in_instr[31:21] == '0)
          dec = mk_dec(in_instr[20] ? ALU_EBREAK : ALU_ECALL, OP1_ZERO, OP2_ZERO, 1'b0);
      end
      default: ;
    endcase
  end

  // Operand selection.
  always_comb begin
    op1_d = '0;
    case (dec.op1_src)
      OP1_RS1: op1_d = rs1_data;
      OP1_PC:  op1_d = in_pc;
      default: op1_d = '0;
    endcase
    op2_d = '0;
    case (dec.op2_src)
      OP2_RS2:   op2_d = rs2_data;
      OP2_IMM:   op2_d = imm;
      OP2_SHAMT: op2_d = XLEN'(in_instr[20 +: SHAMT_W]);
      default:   op2_d = '0;
    endcase
    rd_we_d = dec.wb && (rd_a != '0);
  end

  // Slot control: flush beats accept, accept beats pop.
  always_comb begin
    valid_d = valid_q;
    load    = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      load    = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= ALU_ADD;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        op1_q   <= op1_d;
        op2_q   <= op2_d;
        sel_q   <= dec.sel;
        rd_q    <= rd_a;
        rd_we_q <= rd_we_d;
        ill_q   <= dec.ill;
      end
    end
  end

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign select    = SEL_W'(sel_q);
  assign rd        = rd_q;
  assign rd_we     = rd_we_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage at XLEN=32 with immediate-assertion checks.
module tb_alu_decode_stage;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, rs1_data, rs2_data, op1, op2;
  logic [4:0]      select, rd;
  logic            rd_we, illegal;

  int n_chk  = 0;
  int n_fail = 0;

  alu_decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .select(select), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] e1, input logic [31:0] e2,
                         input alu_op_e esel, input logic ewe, input logic eill);
    drive(1'b1, ins, 32'h0, r1, r2);
    out_ready = 1'b1;
    tick();
    chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, ".op1"}, 64'(op1), 64'(e1));
    chk({tag, ".op2"}, 64'(op2), 64'(e2));
    chk({tag, ".sel"}, 64'(select), 64'(esel));
    chk({tag, ".rd_we"}, 64'(rd_we), 64'(ewe));
    chk({tag, ".illegal"}, 64'(illegal), 64'(eill));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #12;
    chk("rst.valid", 64'(out_valid), 64'(1'b0));
    chk("rst.in_ready", 64'(in_ready), 64'(1'b1));
    chk("rst.sel", 64'(select), 64'(ALU_ADD));
    chk("rst.op1", 64'(op1), 64'h0);
    chk("rst.op2", 64'(op2), 64'h0);
    chk("rst.rd", 64'(rd), 64'h0);
    chk("rst.rd_we", 64'(rd_we), 64'(1'b0));
    chk("rst.illegal", 64'(illegal), 64'(1'b0));
    rst_n = 1'b1;
    tick();

    // ADDI x5,x1,-1 with single-cycle latency
    drive(1'b1, 32'hFFF08293, 32'h0, 32'd5, 32'h0);
    tick();
    chk("addi.valid", 64'(out_valid), 64'(1'b1));
    chk("addi.op1", 64'(op1), 64'h5);
    chk("addi.op2", 64'(op2), 64'hFFFF_FFFF);
    chk("addi.sel", 64'(select), 64'(ALU_ADD));
    chk("addi.rd", 64'(rd), 64'd5);
    chk("addi.rd_we", 64'(rd_we), 64'(1'b1));
    chk("addi.illegal", 64'(illegal), 64'(1'b0));

    // Pop without accept keeps payload
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("pop.valid", 64'(out_valid), 64'(1'b0));
    chk("pop.op1_kept", 64'(op1), 64'h5);

    // SUB x3,x1,x2 then stall three cycles
    drive(1'b1, 32'h402081B3, 32'h0, 32'd10, 32'd3);
    out_ready = 1'b0;
    tick();
    chk("sub.valid", 64'(out_valid), 64'(1'b1));
    chk("sub.op1", 64'(op1), 64'd10);
    chk("sub.op2", 64'(op2), 64'd3);
    chk("sub.sel", 64'(select), 64'(ALU_SUB));
    chk("sub.rd", 64'(rd), 64'd3);
    chk("sub.rd_we", 64'(rd_we), 64'(1'b1));
    drive(1'b1, 32'h12345097, 32'h100, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    #1;
    chk("stall.in_ready", 64'(in_ready), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.valid", 64'(out_valid), 64'(1'b1));
      chk("stall.op1", 64'(op1), 64'd10);
      chk("stall.op2", 64'(op2), 64'd3);
      chk("stall.sel", 64'(select), 64'(ALU_SUB));
      chk("stall.in_ready", 64'(in_ready), 64'(1'b0));
    end

    // Pop and accept AUIPC x1,0x12345 in the same cycle
    out_ready = 1'b1;
    #1;
    chk("swap.in_ready", 64'(in_ready), 64'(1'b1));
    tick();
    chk("auipc.valid", 64'(out_valid), 64'(1'b1));
    chk("auipc.op1", 64'(op1), 64'h100);
    chk("auipc.op2", 64'(op2), 64'h1234_5000);
    chk("auipc.sel", 64'(select), 64'(ALU_AUIPC));
    chk("auipc.rd", 64'(rd), 64'd1);
    chk("auipc.rd_we", 64'(rd_we), 64'(1'b1));

    run_vec("zero",   32'h00000000, 32'd7, 32'd9, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b1);
    run_vec("addw32", 32'h003100BB, 32'd7, 32'd9, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b1);
    run_vec("nop",    32'h00000013, 32'd0, 32'd0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0);
    run_vec("lui",    32'hABCDE3B7, 32'd7, 32'd9, 32'h0, 32'hABCD_E000, ALU_LUI, 1'b1, 1'b0);
    run_vec("srai",   32'h4032D213, 32'h8000_0000, 32'd9, 32'h8000_0000, 32'd3, ALU_SRAI,
            1'b1, 1'b0);
    run_vec("slli32", 32'h02009093, 32'd7, 32'd9, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b1);
    run_vec("rsvd_f7", 32'h40002033, 32'd7, 32'd9, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b1);
    run_vec("sltiu",  32'hFFB13313, 32'd20, 32'd9, 32'd20, 32'hFFFF_FFFB, ALU_SLTU,
            1'b1, 1'b0);
    run_vec("add_x0", 32'h00208033, 32'd4, 32'd6, 32'd4, 32'd6, ALU_ADD, 1'b0, 1'b0);
    run_vec("ecall",  32'h00000073, 32'd7, 32'd9, 32'h0, 32'h0, ALU_ECALL, 1'b0, 1'b0);
    run_vec("ebreak", 32'h00100073, 32'd7, 32'd9, 32'h0, 32'h0, ALU_EBREAK, 1'b0, 1'b0);
    run_vec("ftso",   32'h8330000F, 32'd7, 32'd9, 32'h0, 32'h0, ALU_FENCE_TSO, 1'b0, 1'b0);
    run_vec("pause",  32'h0100000F, 32'd7, 32'd9, 32'h0, 32'h0, ALU_PAUSE, 1'b0, 1'b0);

    // Flush while full and accepting: nothing issues
    drive(1'b1, 32'h402081B3, 32'h0, 32'd10, 32'd3);
    out_ready = 1'b0;
    tick();
    chk("pre_flush.valid", 64'(out_valid), 64'(1'b1));
    drive(1'b1, 32'hFFF08293, 32'h0, 32'd5, 32'h0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush.valid", 64'(out_valid), 64'(1'b0));
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("post_flush.valid", 64'(out_valid), 64'(1'b0));

    // Asynchronous reset while holding a stalled entry
    drive(1'b1, 32'h402081B3, 32'h0, 32'd10, 32'd3);
    out_ready = 1'b0;
    tick();
    chk("pre_rst.valid", 64'(out_valid), 64'(1'b1));
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(out_valid), 64'(1'b0));
    chk("arst.sel", 64'(select), 64'(ALU_ADD));
    chk("arst.in_ready", 64'(in_ready), 64'(1'b1));
    chk("arst.op1", 64'(op1), 64'h0);
    chk("arst.rd_we", 64'(rd_we), 64'(1'b0));
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst.valid", 64'(out_valid), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
